blackjack_input_ctrl: RTL

Front-end that produces the command side of the blackjack_core interface from four raw, bouncy, asynchronous pushbuttons. It emits the btn_hit, btn_stand, btn_double, btn_start, rng_load and rng_seed signals that blackjack_core consumes. Per button it synchronises, debounces, edge-detects and arbitrates. On a start press it sequences an RNG seed load ahead of btn_start; the seed is captured from a free-running counter, so human timing supplies the entropy.

---
 rtl/blackjack_pkg.sv | 28 ++
 rtl/blackjack_input_ctrl_debounce.sv | 63 ++++++
 rtl/blackjack_input_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/blackjack_pkg.sv
// Shared definitions for the blackjack pushbutton front-end.
package blackjack_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        GAP   = 2'd2,
        START = 2'd3
    } bj_state_e;

    localparam int NUM_BTNS   = 4;
    localparam int BTN_HIT    = 0;
    localparam int BTN_STAND  = 1;
    localparam int BTN_DOUBLE = 2;
    localparam int BTN_START  = 3;

    localparam logic [15:0] SEED_SALT_DEFAULT = 16'hB1AC;
    // An all-zero seed would lock the downstream LFSR, so it is replaced.
    localparam logic [15:0] SEED_ZERO_SUB     = 16'h0001;

    function automatic logic [15:0] make_seed(input logic [15:0] cnt,
                                              input logic [15:0] salt);
        logic [15:0] s;
        s = cnt ^ salt;
        return (s == 16'h0000) ? SEED_ZERO_SUB : s;
    endfunction

endpackage

// File: rtl/blackjack_input_ctrl_debounce.sv
// One pushbutton: 2-flop synchroniser, counting debouncer and registered
// rising-edge detector. press_o pulses one cycle per accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic press_o
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          stable_dly_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            stable_d = ~stable_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Debounce state plus a registered 0->1 detector on the stable level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            press_q      <= stable_q & ~stable_dly_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/blackjack_input_ctrl.sv
// Pushbutton front-end for blackjack_core: debounces four buttons,
// arbitrates presses and sequences an RNG seed load ahead of btn_start.
module blackjack_input_ctrl
    import blackjack_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [15:0] SEED_SALT       = SEED_SALT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        raw_hit,
    input  logic        raw_stand,
    input  logic        raw_double,
    input  logic        raw_start,
    output logic        btn_hit,
    output logic        btn_stand,
    output logic        btn_double,
    output logic        btn_start,
    output logic        rng_load,
    output logic [15:0] rng_seed
);

    logic [NUM_BTNS-1:0] raw_vec;
    logic [NUM_BTNS-1:0] press;

    bj_state_e   state_q, state_d;
    logic [15:0] cnt_q;
    logic [15:0] seed_q, seed_d;
    logic        hit_q, hit_d;
    logic        stand_q, stand_d;
    logic        double_q, double_d;
    logic        start_q, start_d;
    logic        load_q, load_d;

    assign raw_vec[BTN_HIT]    = raw_hit;
    assign raw_vec[BTN_STAND]  = raw_stand;
    assign raw_vec[BTN_DOUBLE] = raw_double;
    assign raw_vec[BTN_START]  = raw_start;

    for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw_i  (raw_vec[b]),
            .press_o(press[b])
        );
    end

    // Free-running entropy counter; press timing samples it for the seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_q + 16'd1;
    end

    // Next state and next outputs; same-cycle presses resolve
    // start > stand > double > hit and losers are simply dropped.
    always_comb begin
        state_d  = state_q;
        seed_d   = seed_q;
        hit_d    = 1'b0;
        stand_d  = 1'b0;
        double_d = 1'b0;
        start_d  = 1'b0;
        load_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (press[BTN_START]) begin
                    state_d = LOAD;
                    load_d  = 1'b1;
                    seed_d  = make_seed(cnt_q, SEED_SALT);
                end else if (press[BTN_STAND]) begin
                    stand_d = 1'b1;
                end else if (press[BTN_DOUBLE]) begin
                    double_d = 1'b1;
                end else if (press[BTN_HIT]) begin
                    hit_d = 1'b1;
                end
            end
            LOAD:  state_d = GAP;
            GAP: begin
                state_d = START;
                start_d = 1'b1;
            end
            START: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered outputs; reset aborts any sequence in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            seed_q   <= '0;
            hit_q    <= 1'b0;
            stand_q  <= 1'b0;
            double_q <= 1'b0;
            start_q  <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            seed_q   <= seed_d;
            hit_q    <= hit_d;
            stand_q  <= stand_d;
            double_q <= double_d;
            start_q  <= start_d;
            load_q   <= load_d;
        end
    end

    assign btn_hit    = hit_q;
    assign btn_stand  = stand_q;
    assign btn_double = double_q;
    assign btn_start  = start_q;
    assign rng_load   = load_q;
    assign rng_seed   = seed_q;

endmodule
